// File: rtl/gray_if_pkg.sv
// rtl/gray_if_pkg.sv - shared gray-image memory interface constants and types
package gray_if_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;
    localparam int IMG_W  = 128;
    localparam int IMG_H  = 128;
    localparam int ROW_W  = 7;
    localparam int COL_W  = 7;

    localparam logic REQ_LBP = 1'b0;
    localparam logic REQ_AUX = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
    } rtag_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hf) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin picker with locked-owner override
module rr_pick2 (
    input  logic       en,
    input  logic       ptr,
    input  logic [1:0] req,
    input  logic       own_valid,
    input  logic       own_id,
    input  logic       own_under_limit,
    output logic [1:0] gnt
);

    logic own_wins;

    // A locked owner keeps the port until its burst quota runs out, but only
    // while somebody else is actually waiting for it.
    assign own_wins = own_valid && req[own_id] && (own_under_limit || !req[~own_id]);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (own_wins) begin
                gnt[own_id] = 1'b1;
            end else if (req[ptr]) begin
                gnt[ptr] = 1'b1;
            end else if (req[~ptr]) begin
                gnt[~ptr] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gray_port_arbiter.sv
// rtl/gray_port_arbiter.sv - round-robin arbiter for the shared gray-memory read port
module gray_port_arbiter #(
    parameter int ADDR_W    = gray_if_pkg::ADDR_W,
    parameter int DATA_W    = gray_if_pkg::DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gray_ready,
    output logic              gray_req,
    output logic [ADDR_W-1:0] gray_addr,
    input  logic [DATA_W-1:0] gray_data,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata
);

    import gray_if_pkg::*;

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    logic [1:0] req_v;
    logic [1:0] lock_v;
    logic [1:0] gnt_v;
    logic       ptr;
    logic       owner_valid;
    logic       owner_id;
    logic [3:0] burst_cnt;
    logic       accept;
    logic       accept_id;
    rtag_t      tag_q;

    assign req_v  = {req1, req0};
    assign lock_v = {lock1, lock0};

    rr_pick2 u_pick (
        .en              (gray_ready && reset),
        .ptr             (ptr),
        .req             (req_v),
        .own_valid       (owner_valid),
        .own_id          (owner_id),
        .own_under_limit (burst_cnt < BURST_LAST),
        .gnt             (gnt_v)
    );

    assign gnt0      = gnt_v[0];
    assign gnt1      = gnt_v[1];
    assign accept    = |(req_v & gnt_v);
    assign accept_id = gnt_v[1];
    assign rdata     = gray_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gray_req    <= 1'b0;
            gray_addr   <= '0;
            ptr         <= REQ_LBP;
            owner_valid <= 1'b0;
            owner_id    <= REQ_LBP;
            burst_cnt   <= 4'd0;
            tag_q       <= '0;
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
        end else begin
            gray_req    <= accept;
            tag_q.valid <= accept;
            tag_q.id    <= accept_id;
            rvalid0     <= tag_q.valid && (tag_q.id == REQ_LBP);
            rvalid1     <= tag_q.valid && (tag_q.id == REQ_AUX);
            if (accept) begin
                gray_addr <= accept_id ? addr1 : addr0;
                ptr       <= ~accept_id;
                if (lock_v[accept_id]) begin
                    owner_valid <= 1'b1;
                    owner_id    <= accept_id;
                    burst_cnt   <= (owner_valid && owner_id == accept_id) ? sat_inc4(burst_cnt) : 4'd0;
                end else begin
                    owner_valid <= 1'b0;
                    burst_cnt   <= 4'd0;
                end
            end else begin
                // Idle cycles, memory-not-ready and an owner dropping its
                // request all end any burst in progress.
                owner_valid <= 1'b0;
                burst_cnt   <= 4'd0;
            end
        end
    end

endmodule
